pipe_scroller: RTL and testbench

Parametrised multi-pipe obstacle generator for the Flappy Bird datapath. Drives NUM_PIPES independent pipe channels from one shared, speed-selectable movement tick. Pipes are released one after another at a fixed spacing and respawn at the right edge with gap heights taken from a fixed table. It freezes on Lost, parks when Start drops, and pulses ScoreTick when a pipe passes the bird column. It sits between the game control FSM and the renderer/collision logic.

---
 rtl/pipe_scroller.sv | 179 +++++++++++++++++
 tb/tb_pipe_scroller.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_scroller.sv
// rtl/pipe_scroller.sv - multi-pipe obstacle generator with shared movement tick
module pipe_scroller #(
  parameter int NUM_PIPES = 3,
  parameter int X_WIDTH   = 10,
  parameter int TICK_DIV  = 500000,
  parameter int SPAWN_X   = 1000,
  parameter int PARK_X    = 1023,
  parameter int PARK_Y    = 75,
  parameter int SPACING   = 350,
  parameter int BIRD_X    = 200
) (
  input  logic                           Clk,
  input  logic                           Reset,
  input  logic                           Start,
  input  logic                           Lost,
  input  logic [1:0]                     SpeedSel,
  output logic [NUM_PIPES*X_WIDTH-1:0]   PipePosX,
  output logic [NUM_PIPES*X_WIDTH-1:0]   PipePosY,
  output logic [NUM_PIPES-1:0]           Active,
  output logic                           Running,
  output logic                           ScoreTick
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

  localparam logic [X_WIDTH-1:0] SPAWN_V  = X_WIDTH'(SPAWN_X);
  localparam logic [X_WIDTH-1:0] PARKX_V  = X_WIDTH'(PARK_X);
  localparam logic [X_WIDTH-1:0] PARKY_V  = X_WIDTH'(PARK_Y);
  localparam logic [X_WIDTH-1:0] BIRD_V   = X_WIDTH'(BIRD_X);
  // X of the predecessor at which the next pipe is released
  localparam logic [X_WIDTH-1:0] REL_V    = X_WIDTH'(SPAWN_X - SPACING);

  // Gap heights, consumed in order and wrapping after eight entries
  function automatic logic [X_WIDTH-1:0] table_y(input logic [2:0] idx);
    case (idx)
      3'd0:    table_y = X_WIDTH'(300);
      3'd1:    table_y = X_WIDTH'(100);
      3'd2:    table_y = X_WIDTH'(210);
      3'd3:    table_y = X_WIDTH'(250);
      3'd4:    table_y = X_WIDTH'(170);
      3'd5:    table_y = X_WIDTH'(190);
      3'd6:    table_y = X_WIDTH'(230);
      default: table_y = X_WIDTH'(200);
    endcase
  endfunction

  logic [1:0]           state_q, state_d;
  logic [31:0]          div_q, div_d;
  logic [2:0]           ptr_q, ptr_d;
  logic [NUM_PIPES-1:0] active_q, active_d;
  logic                 score_q, score_d;
  logic [X_WIDTH-1:0]   x_q [NUM_PIPES];
  logic [X_WIDTH-1:0]   x_d [NUM_PIPES];
  logic [X_WIDTH-1:0]   y_q [NUM_PIPES];
  logic [X_WIDTH-1:0]   y_d [NUM_PIPES];

  logic [31:0]          limit_m1;
  logic                 tick;
  logic [NUM_PIPES-1:0] rel_ok;
  logic [2:0]           cnt;

  // Move period follows SpeedSel live; >= lets a shortened period fire at once
  always_comb begin
    limit_m1 = (32'(TICK_DIV) >> SpeedSel) - 32'd1;
    tick     = (state_q == ST_RUN) && (div_q >= limit_m1);
  end

  // Pipe k may be released when its predecessor is active at the release column
  always_comb begin
    rel_ok = '0;
    for (int k = 1; k < NUM_PIPES; k++) begin
      rel_ok[k] = active_q[k-1] && (x_q[k-1] == REL_V);
    end
  end

  // Next-state: park on Start=0, launch pipe 0, move/respawn/release on tick
  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    ptr_d    = ptr_q;
    active_d = active_q;
    score_d  = 1'b0;
    cnt      = 3'd0;
    x_d      = x_q;
    y_d      = y_q;
    if (!Start) begin
      state_d  = ST_IDLE;
      div_d    = 32'd0;
      ptr_d    = 3'd0;
      active_d = '0;
      for (int k = 0; k < NUM_PIPES; k++) begin
        x_d[k] = PARKX_V;
        y_d[k] = PARKY_V;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d     = ST_RUN;
          div_d       = 32'd0;
          active_d[0] = 1'b1;
          x_d[0]      = SPAWN_V;
          y_d[0]      = table_y(3'd0);
          ptr_d       = 3'd1;
        end
        ST_RUN: begin
          if (Lost) begin
            state_d = ST_HALT;
          end else if (tick) begin
            div_d = 32'd0;
            // Table entries are handed out in ascending pipe order
            for (int k = 0; k < NUM_PIPES; k++) begin
              if (active_q[k]) begin
                if (x_q[k] == '0) begin
                  x_d[k] = SPAWN_V;
                  y_d[k] = table_y(ptr_q + cnt);
                  cnt    = cnt + 3'd1;
                end else begin
                  x_d[k] = x_q[k] - X_WIDTH'(1);
                  if (x_q[k] == BIRD_V) score_d = 1'b1;
                end
              end else if (rel_ok[k]) begin
                active_d[k] = 1'b1;
                x_d[k]      = SPAWN_V;
                y_d[k]      = table_y(ptr_q + cnt);
                cnt         = cnt + 3'd1;
              end
            end
            ptr_d = ptr_q + cnt;
          end else begin
            div_d = div_q + 32'd1;
          end
        end
        ST_HALT: begin
          state_d = ST_HALT;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State registers with synchronous reset to the parked condition
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= ST_IDLE;
      div_q    <= 32'd0;
      ptr_q    <= 3'd0;
      active_q <= '0;
      score_q  <= 1'b0;
      for (int k = 0; k < NUM_PIPES; k++) begin
        x_q[k] <= PARKX_V;
        y_q[k] <= PARKY_V;
      end
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      ptr_q    <= ptr_d;
      active_q <= active_d;
      score_q  <= score_d;
      for (int k = 0; k < NUM_PIPES; k++) begin
        x_q[k] <= x_d[k];
        y_q[k] <= y_d[k];
      end
    end
  end

  for (genvar g = 0; g < NUM_PIPES; g++) begin : g_pack
    assign PipePosX[g*X_WIDTH +: X_WIDTH] = x_q[g];
    assign PipePosY[g*X_WIDTH +: X_WIDTH] = y_q[g];
  end

  assign Active    = active_q;
  assign Running   = (state_q == ST_RUN);
  assign ScoreTick = score_q;

endmodule

// File: tb/tb_pipe_scroller.sv
// tb/tb_pipe_scroller.sv - directed self-checking bench for pipe_scroller
module tb_pipe_scroller;

  logic        Clk = 1'b0;
  logic        Reset, Start, Lost;
  logic [1:0]  SpeedSel;
  logic [29:0] PipePosX, PipePosY;
  logic [2:0]  Active;
  logic        Running, ScoreTick;

  logic        Reset2, Start2, Lost2;
  logic [1:0]  SpeedSel2;
  logic [29:0] PipePosX2, PipePosY2;
  logic [2:0]  Active2;
  logic        Running2, ScoreTick2;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int base1 = 0;
  int base2 = 0;
  int score_cnt = 0;
  logic [29:0] ex, ey;

  always #5 Clk = ~Clk;

  pipe_scroller #(
    .NUM_PIPES(3), .X_WIDTH(10), .TICK_DIV(4), .SPAWN_X(20), .PARK_X(1023),
    .PARK_Y(75), .SPACING(8), .BIRD_X(10)
  ) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Lost(Lost), .SpeedSel(SpeedSel),
    .PipePosX(PipePosX), .PipePosY(PipePosY), .Active(Active),
    .Running(Running), .ScoreTick(ScoreTick)
  );

  pipe_scroller #(
    .NUM_PIPES(3), .X_WIDTH(10), .TICK_DIV(4), .SPAWN_X(16), .PARK_X(1023),
    .PARK_Y(75), .SPACING(16), .BIRD_X(10)
  ) dut2 (
    .Clk(Clk), .Reset(Reset2), .Start(Start2), .Lost(Lost2), .SpeedSel(SpeedSel2),
    .PipePosX(PipePosX2), .PipePosY(PipePosY2), .Active(Active2),
    .Running(Running2), .ScoreTick(ScoreTick2)
  );

  task automatic step();
    @(posedge Clk);
    #1;
    cyc++;
    if (ScoreTick === 1'b1) score_cnt++;
  endtask

  task automatic run1(input int n);
    while ((cyc - base1) < n) step();
  endtask

  task automatic run2(input int n);
    while ((cyc - base2) < n) step();
  endtask

  task automatic test_reset();
    repeat (3) step();
    ex = {10'd1023, 10'd1023, 10'd1023}; ey = {10'd75, 10'd75, 10'd75};
    vectors++; if (PipePosX !== ex) begin miscompares++; $display("FAIL rst_x got %h want %h", PipePosX, ex); end
    vectors++; if (PipePosY !== ey) begin miscompares++; $display("FAIL rst_y got %h want %h", PipePosY, ey); end
    vectors++; if (Active !== 3'b000) begin miscompares++; $display("FAIL rst_active got %b want 000", Active); end
    vectors++; if (Running !== 1'b0) begin miscompares++; $display("FAIL rst_running got %b want 0", Running); end
    vectors++; if (ScoreTick !== 1'b0) begin miscompares++; $display("FAIL rst_score got %b want 0", ScoreTick); end
    Reset = 1'b0;
    step();
    base1 = cyc;
    score_cnt = 0;
    ex = {10'd1023, 10'd1023, 10'd20}; ey = {10'd75, 10'd75, 10'd300};
    vectors++; if (PipePosX !== ex) begin miscompares++; $display("FAIL launch_x got %h want %h", PipePosX, ex); end
    vectors++; if (PipePosY !== ey) begin miscompares++; $display("FAIL launch_y got %h want %h", PipePosY, ey); end
    vectors++; if (Active !== 3'b001) begin miscompares++; $display("FAIL launch_active got %b want 001", Active); end
    vectors++; if (Running !== 1'b1) begin miscompares++; $display("FAIL launch_running got %b want 1", Running); end
  endtask

  task automatic test_movement();
    run1(3);
    ex = {10'd1023, 10'd1023, 10'd20};
    vectors++; if (PipePosX !== ex) begin miscompares++; $display("FAIL nomove_t3 got %h want %h", PipePosX, ex); end
    run1(4);
    ex = {10'd1023, 10'd1023, 10'd19};
    vectors++; if (PipePosX !== ex) begin miscompares++; $display("FAIL move_t4 got %h want %h", PipePosX, ex); end
    run1(32);
    ex = {10'd1023, 10'd1023, 10'd12};
    vectors++; if (PipePosX !== ex) begin miscompares++; $display("FAIL move_t32 got %h want %h", PipePosX, ex); end
    vectors++; if (Active !== 3'b001) begin miscompares++; $display("FAIL active_t32 got %b want 001", Active); end
    run1(36);
    ex = {10'd1023, 10'd20, 10'd11}; ey = {10'd75, 10'd100, 10'd300};
    vectors++; if (PipePosX !== ex) begin miscompares++; $display("FAIL rel1_x got %h want %h", PipePosX, ex); end
    vectors++; if (PipePosY !== ey) begin miscompares++; $display("FAIL rel1_y got %h want %h", PipePosY, ey); end
    vectors++; if (Active !== 3'b011) begin miscompares++; $display("FAIL rel1_active got %b want 011", Active); end
  endtask

  task automatic test_scoring();
    run1(43);
    vectors++; if (ScoreTick !== 1'b0) begin miscompares++; $display("FAIL score_t43 got %b want 0", ScoreTick); end
    run1(44);
    ex = {10'd1023, 10'd18, 10'd9};
    vectors++; if (ScoreTick !== 1'b1) begin miscompares++; $display("FAIL score_t44 got %b want 1", ScoreTick); end
    vectors++; if (PipePosX !== ex) begin miscompares++; $display("FAIL score_x got %h want %h", PipePosX, ex); end
    run1(45);
    vectors++; if (ScoreTick !== 1'b0) begin miscompares++; $display("FAIL score_t45 got %b want 0", ScoreTick); end
  endtask

  task automatic test_release2();
    run1(72);
    ex = {10'd20, 10'd11, 10'd2}; ey = {10'd210, 10'd100, 10'd300};
    vectors++; if (PipePosX !== ex) begin miscompares++; $display("FAIL rel2_x got %h want %h", PipePosX, ex); end
    vectors++; if (PipePosY !== ey) begin miscompares++; $display("FAIL rel2_y got %h want %h", PipePosY, ey); end
    vectors++; if (Active !== 3'b111) begin miscompares++; $display("FAIL rel2_active got %b want 111", Active); end
  endtask

  task automatic test_respawn();
    run1(80);
    ex = {10'd18, 10'd9, 10'd0};
    vectors++; if (PipePosX !== ex) begin miscompares++; $display("FAIL zero_x got %h want %h", PipePosX, ex); end
    run1(84);
    ex = {10'd17, 10'd8, 10'd20}; ey = {10'd210, 10'd100, 10'd250};
    vectors++; if (PipePosX !== ex) begin miscompares++; $display("FAIL respawn_x got %h want %h", PipePosX, ex); end
    vectors++; if (PipePosY !== ey) begin miscompares++; $display("FAIL respawn_y got %h want %h", PipePosY, ey); end
    run1(240);
    ex = {10'd20, 10'd11, 10'd2}; ey = {10'd300, 10'd200, 10'd230};
    vectors++; if (PipePosX !== ex) begin miscompares++; $display("FAIL wrap_x got %h want %h", PipePosX, ex); end
    vectors++; if (PipePosY !== ey) begin miscompares++; $display("FAIL wrap_y got %h want %h", PipePosY, ey); end
    vectors++; if (score_cnt !== 7) begin miscompares++; $display("FAIL score_count got %0d want 7", score_cnt); end
  endtask

  task automatic test_speed();
    SpeedSel = 2'd2;
    run1(241);
    ex = {10'd19, 10'd10, 10'd1};
    vectors++; if (PipePosX !== ex) begin miscompares++; $display("FAIL fast_t241 got %h want %h", PipePosX, ex); end
    run1(242);
    ex = {10'd18, 10'd9, 10'd0};
    vectors++; if (PipePosX !== ex) begin miscompares++; $display("FAIL fast_t242 got %h want %h", PipePosX, ex); end
    vectors++; if (ScoreTick !== 1'b1) begin miscompares++; $display("FAIL fast_score got %b want 1", ScoreTick); end
    run1(243);
    ex = {10'd17, 10'd8, 10'd20}; ey = {10'd300, 10'd200, 10'd100};
    vectors++; if (PipePosX !== ex) begin miscompares++; $display("FAIL fast_t243_x got %h want %h", PipePosX, ex); end
    vectors++; if (PipePosY !== ey) begin miscompares++; $display("FAIL fast_t243_y got %h want %h", PipePosY, ey); end
  endtask

  task automatic test_lost();
    Lost = 1'b1;
    run1(244);
    ex = {10'd17, 10'd8, 10'd20}; ey = {10'd300, 10'd200, 10'd100};
    vectors++; if (PipePosX !== ex) begin miscompares++; $display("FAIL lost_x got %h want %h", PipePosX, ex); end
    vectors++; if (Running !== 1'b0) begin miscompares++; $display("FAIL lost_running got %b want 0", Running); end
    run1(294);
    vectors++; if (PipePosX !== ex) begin miscompares++; $display("FAIL halt_x got %h want %h", PipePosX, ex); end
    vectors++; if (PipePosY !== ey) begin miscompares++; $display("FAIL halt_y got %h want %h", PipePosY, ey); end
    vectors++; if (Active !== 3'b111) begin miscompares++; $display("FAIL halt_active got %b want 111", Active); end
    vectors++; if (score_cnt !== 8) begin miscompares++; $display("FAIL halt_score_count got %0d want 8", score_cnt); end
    Lost = 1'b0;
    Start = 1'b0;
    run1(295);
    ex = {10'd1023, 10'd1023, 10'd1023}; ey = {10'd75, 10'd75, 10'd75};
    vectors++; if (PipePosX !== ex) begin miscompares++; $display("FAIL park_x got %h want %h", PipePosX, ex); end
    vectors++; if (PipePosY !== ey) begin miscompares++; $display("FAIL park_y got %h want %h", PipePosY, ey); end
    vectors++; if (Active !== 3'b000) begin miscompares++; $display("FAIL park_active got %b want 000", Active); end
  endtask

  task automatic test_restart();
    Start = 1'b1;
    SpeedSel = 2'd0;
    run1(296);
    ex = {10'd1023, 10'd1023, 10'd20}; ey = {10'd75, 10'd75, 10'd300};
    vectors++; if (PipePosX !== ex) begin miscompares++; $display("FAIL restart_x got %h want %h", PipePosX, ex); end
    vectors++; if (PipePosY !== ey) begin miscompares++; $display("FAIL restart_y got %h want %h", PipePosY, ey); end
    vectors++; if (Running !== 1'b1) begin miscompares++; $display("FAIL restart_running got %b want 1", Running); end
    run1(298);
    SpeedSel = 2'd1;
    run1(299);
    ex = {10'd1023, 10'd1023, 10'd19};
    vectors++; if (PipePosX !== ex) begin miscompares++; $display("FAIL ge_tick got %h want %h", PipePosX, ex); end
    run1(300);
    vectors++; if (PipePosX !== ex) begin miscompares++; $display("FAIL half_t300 got %h want %h", PipePosX, ex); end
    run1(301);
    ex = {10'd1023, 10'd1023, 10'd18};
    vectors++; if (PipePosX !== ex) begin miscompares++; $display("FAIL half_t301 got %h want %h", PipePosX, ex); end
    run1(302);
    Start = 1'b0;
    run1(303);
    ex = {10'd1023, 10'd1023, 10'd1023};
    vectors++; if (PipePosX !== ex) begin miscompares++; $display("FAIL midpark_x got %h want %h", PipePosX, ex); end
    vectors++; if (Running !== 1'b0) begin miscompares++; $display("FAIL midpark_running got %b want 0", Running); end
  endtask

  task automatic test_simultaneous();
    Reset2 = 1'b0;
    step();
    base2 = cyc;
    ex = {10'd1023, 10'd1023, 10'd16};
    vectors++; if (PipePosX2 !== ex) begin miscompares++; $display("FAIL sim_launch got %h want %h", PipePosX2, ex); end
    run2(64);
    ex = {10'd1023, 10'd1023, 10'd0};
    vectors++; if (PipePosX2 !== ex) begin miscompares++; $display("FAIL sim_t64 got %h want %h", PipePosX2, ex); end
    run2(68);
    ex = {10'd1023, 10'd16, 10'd16}; ey = {10'd75, 10'd210, 10'd100};
    vectors++; if (PipePosX2 !== ex) begin miscompares++; $display("FAIL sim2_x got %h want %h", PipePosX2, ex); end
    vectors++; if (PipePosY2 !== ey) begin miscompares++; $display("FAIL sim2_y got %h want %h", PipePosY2, ey); end
    vectors++; if (Active2 !== 3'b011) begin miscompares++; $display("FAIL sim2_active got %b want 011", Active2); end
    run2(136);
    ex = {10'd16, 10'd16, 10'd16}; ey = {10'd190, 10'd170, 10'd250};
    vectors++; if (PipePosX2 !== ex) begin miscompares++; $display("FAIL sim3_x got %h want %h", PipePosX2, ex); end
    vectors++; if (PipePosY2 !== ey) begin miscompares++; $display("FAIL sim3_y got %h want %h", PipePosY2, ey); end
    vectors++; if (Active2 !== 3'b111) begin miscompares++; $display("FAIL sim3_active got %b want 111", Active2); end
  endtask

  initial begin
    Reset = 1'b1; Start = 1'b1; Lost = 1'b0; SpeedSel = 2'd0;
    Reset2 = 1'b1; Start2 = 1'b1; Lost2 = 1'b0; SpeedSel2 = 2'd0;
    test_reset();
    test_movement();
    test_scoring();
    test_release2();
    test_respawn();
    test_speed();
    test_lost();
    test_restart();
    test_simultaneous();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
